// File: rtl/qracc_pkg.sv
// Shared types for the QRAcc control path: sequencer states, config fields and
// the per-cycle sequencer control bundle.
package qracc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRIVE,
    ST_CONVERT,
    ST_ACCUM,
    ST_WRITEBACK,
    ST_DONE
  } seq_state_t;

  typedef struct packed {
    logic [2:0] n_input_bits;
    logic       binary;
    logic [2:0] adc_ref_range_shifts;
  } qracc_config_t;

  typedef struct packed {
    logic       wl_en;
    logic       adc_start;
    logic       acc_clear;
    logic       acc_en;
    logic [2:0] bit_idx;
    logic       acc_msb;
  } qracc_seq_ctrl_t;

  // Index of the last bit plane; binary mode collapses to a single plane.
  function automatic logic [2:0] last_plane(input qracc_config_t cfg);
    return cfg.binary ? 3'd0 : cfg.n_input_bits;
  endfunction

endpackage

// File: rtl/qracc_op_sequencer.sv
// Operation sequencer: per row tile, load activations, then a bit-serial
// drive/convert/accumulate loop, and finish with a writeback handshake.
module qracc_op_sequencer
  import qracc_pkg::*;
#(
  parameter int NUM_TILES   = 4,
  parameter int ADC_LATENCY = 2,
  parameter int TILE_W      = (NUM_TILES > 1) ? $clog2(NUM_TILES) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start_i,
  input  logic              clear_i,
  input  logic              stall_i,
  input  logic [2:0]        n_input_bits_cfg_i,
  input  logic              binary_cfg_i,
  input  logic [2:0]        adc_ref_range_shifts_i,
  input  logic              act_valid_i,
  output logic              act_ready_o,
  output logic              wl_en_o,
  output logic              adc_start_o,
  output logic [2:0]        adc_ref_shift_o,
  output logic              acc_clear_o,
  output logic              acc_en_o,
  output logic [2:0]        bit_idx_o,
  output logic              acc_msb_o,
  output logic [TILE_W-1:0] tile_idx_o,
  output logic              wb_valid_o,
  input  logic              wb_ready_i,
  output logic              busy_o,
  output logic              done_o
);

  localparam int                CNT_W     = (ADC_LATENCY > 1) ? $clog2(ADC_LATENCY) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD  = CNT_W'(ADC_LATENCY - 1);
  localparam logic [TILE_W-1:0] LAST_TILE = TILE_W'(NUM_TILES - 1);

  seq_state_t        state, state_d;
  qracc_config_t     cfg;
  qracc_seq_ctrl_t   ctrl;
  logic              start_q, armed, start_edge, accept;
  logic              last_bit, last_tile;
  logic [2:0]        last_bit_q, bit_idx, bit_d;
  logic [TILE_W-1:0] tile_idx, tile_d;
  logic [CNT_W-1:0]  cnt, cnt_d;

  assign cfg = '{n_input_bits:         n_input_bits_cfg_i,
                 binary:               binary_cfg_i,
                 adc_ref_range_shifts: adc_ref_range_shifts_i};

  // armed stays low until start_i has been seen low, so a level held through
  // reset does not count as a rising edge.
  assign start_edge = start_i & ~start_q & armed;
  assign last_bit   = (bit_idx == last_bit_q);
  assign last_tile  = (tile_idx == LAST_TILE);

  always_comb begin
    // NOTE: every signal driven here gets a default first so no path leaves it unassigned and infers a latch.
    state_d     = state;
    bit_d       = bit_idx;
    tile_d      = tile_idx;
    cnt_d       = cnt;
    accept      = 1'b0;
    ctrl        = '0;
    ctrl.bit_idx = bit_idx;
    act_ready_o = 1'b0;
    wb_valid_o  = 1'b0;
    done_o      = 1'b0;

    case (state)
      ST_IDLE: begin
        if (start_edge) begin
          accept  = 1'b1;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        act_ready_o = 1'b1;
        if (act_valid_i) begin
          ctrl.acc_clear = 1'b1;
          bit_d          = 3'd0;
          state_d        = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        ctrl.wl_en     = 1'b1;
        ctrl.adc_start = 1'b1;
        ctrl.acc_msb   = last_bit;
        cnt_d          = CNT_LOAD;
        state_d        = ST_CONVERT;
      end
      ST_CONVERT: begin
        ctrl.wl_en   = 1'b1;
        ctrl.acc_msb = last_bit;
        if (cnt == '0) state_d = ST_ACCUM;
        else           cnt_d   = cnt - CNT_W'(1);
      end
      ST_ACCUM: begin
        ctrl.acc_en  = 1'b1;
        ctrl.acc_msb = last_bit;
        if (last_bit && last_tile) begin
          state_d = ST_WRITEBACK;
        end else if (last_bit) begin
          tile_d  = tile_idx + TILE_W'(1);
          state_d = ST_LOAD;
        end else begin
          bit_d   = bit_idx + 3'd1;
          state_d = ST_DRIVE;
        end
      end
      ST_WRITEBACK: begin
        wb_valid_o = 1'b1;
        if (wb_ready_i) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        bit_d   = 3'd0;
        tile_d  = '0;
        state_d = ST_IDLE;
      end
      default: begin
        bit_d   = 3'd0;
        tile_d  = '0;
        state_d = ST_IDLE;
      end
    endcase

    // Abort beats freeze; a frozen pulse reappears once because the state holds.
    if (clear_i) begin
      state_d = ST_IDLE;
      bit_d   = 3'd0;
      tile_d  = '0;
      cnt_d   = '0;
      accept  = 1'b0;
    end else if (stall_i) begin
      state_d        = state;
      bit_d          = bit_idx;
      tile_d         = tile_idx;
      cnt_d          = cnt;
      accept         = 1'b0;
      ctrl.adc_start = 1'b0;
      ctrl.acc_clear = 1'b0;
      ctrl.acc_en    = 1'b0;
      act_ready_o    = 1'b0;
      done_o         = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ST_IDLE;
      start_q         <= 1'b0;
      armed           <= 1'b0;
      last_bit_q      <= 3'd0;
      adc_ref_shift_o <= 3'd0;
      bit_idx         <= 3'd0;
      tile_idx        <= '0;
      cnt             <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      state    <= state_d;
      start_q  <= start_i;
      bit_idx  <= bit_d;
      tile_idx <= tile_d;
      cnt      <= cnt_d;
      if (!start_i) armed <= 1'b1;
      if (accept) begin
        last_bit_q      <= last_plane(cfg);
        adc_ref_shift_o <= cfg.adc_ref_range_shifts;
      end
    end
  end

  assign wl_en_o     = ctrl.wl_en;
  assign adc_start_o = ctrl.adc_start;
  assign acc_clear_o = ctrl.acc_clear;
  assign acc_en_o    = ctrl.acc_en;
  assign acc_msb_o   = ctrl.acc_msb;
  assign bit_idx_o   = ctrl.bit_idx;
  assign tile_idx_o  = tile_idx;
  assign busy_o      = (state != ST_IDLE);

endmodule

// File: tb/tb_qracc_op_sequencer.sv
// Bench for qracc_op_sequencer: an operation is modelled as a list of steps
// built at launch, consumed as handshakes/stalls allow, compared every cycle.
`timescale 1ns/1ps
module tb_qracc_op_sequencer;

  localparam int NT  = 2;
  localparam int LAT = 2;
  localparam int TW  = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start_i = 1'b1, clear_i = 1'b0, stall_i = 1'b0;
  logic [2:0]    n_input_bits_cfg_i = 3'd0;
  logic          binary_cfg_i = 1'b0;
  logic [2:0]    adc_ref_range_shifts_i = 3'd0;
  logic          act_valid_i = 1'b0, wb_ready_i = 1'b0;
  logic          act_ready_o, wl_en_o, adc_start_o, acc_clear_o, acc_en_o, acc_msb_o;
  logic [2:0]    adc_ref_shift_o, bit_idx_o;
  logic [TW-1:0] tile_idx_o;
  logic          wb_valid_o, busy_o, done_o;

  qracc_op_sequencer #(.NUM_TILES(NT), .ADC_LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .clear_i(clear_i), .stall_i(stall_i),
    .n_input_bits_cfg_i(n_input_bits_cfg_i), .binary_cfg_i(binary_cfg_i),
    .adc_ref_range_shifts_i(adc_ref_range_shifts_i), .act_valid_i(act_valid_i),
    .act_ready_o(act_ready_o), .wl_en_o(wl_en_o), .adc_start_o(adc_start_o),
    .adc_ref_shift_o(adc_ref_shift_o), .acc_clear_o(acc_clear_o), .acc_en_o(acc_en_o),
    .bit_idx_o(bit_idx_o), .acc_msb_o(acc_msb_o), .tile_idx_o(tile_idx_o),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the whole operation as an ordered list of steps.
  localparam int K_LOAD = 0, K_DRIVE = 1, K_CONV = 2, K_ACC = 3, K_WB = 4, K_DONE = 5;
  typedef struct { int kind; int tile; int bitp; } step_t;
  step_t prog[$];
  int    m_nbits = 1;
  int    m_shift = 0;
  bit    m_start_q = 1'b0;
  bit    m_armed = 1'b0;

  function automatic void build(input int nb);
    prog.delete();
    for (int t = 0; t < NT; t++) begin
      prog.push_back('{K_LOAD, t, (t == 0) ? 0 : nb - 1});
      for (int b = 0; b < nb; b++) begin
        prog.push_back('{K_DRIVE, t, b});
        for (int c = 0; c < LAT; c++) prog.push_back('{K_CONV, t, b});
        prog.push_back('{K_ACC, t, b});
      end
    end
    prog.push_back('{K_WB, NT - 1, nb - 1});
    prog.push_back('{K_DONE, NT - 1, nb - 1});
  endfunction

  initial begin
    bit rise;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        prog.delete();
        m_start_q = 1'b0;
        m_armed   = 1'b0;
        m_shift   = 0;
      end else begin
        rise = start_i && !m_start_q && m_armed;
        if (clear_i) begin
          prog.delete();
        end else if (!stall_i) begin
          if (prog.size() == 0) begin
            if (rise) begin
              m_nbits = binary_cfg_i ? 1 : int'(n_input_bits_cfg_i) + 1;
              m_shift = int'(adc_ref_range_shifts_i);
              build(m_nbits);
            end
          end else if ((prog[0].kind != K_LOAD || act_valid_i) &&
                       (prog[0].kind != K_WB || wb_ready_i)) begin
            prog.delete(0);
          end
        end
        if (!start_i) m_armed = 1'b1;
        m_start_q = start_i;
      end
    end
  end

  // Statistics gathered from the DUT for the directed literal checks.
  int st_busy, st_acc, st_clr, st_done, st_done_at, st_wbv, st_rdy, st_msb;
  int acc_bits[$];
  int acc_tiles[$];

  task automatic clear_stats();
    st_busy = 0; st_acc = 0; st_clr = 0; st_done = 0; st_done_at = 0;
    st_wbv = 0; st_rdy = 0; st_msb = 0;
    acc_bits.delete(); acc_tiles.delete();
  endtask

  always @(negedge clk) begin : compare
    step_t h;
    bit    act, is_dca;
    if (rst !== 1'b1) begin
      act = (prog.size() != 0);
      h   = act ? prog[0] : '{-1, 0, 0};
      is_dca = (h.kind == K_DRIVE || h.kind == K_CONV || h.kind == K_ACC);
      check("busy_o",          busy_o,          act);
      check("act_ready_o",     act_ready_o,     h.kind == K_LOAD && !stall_i);
      check("acc_clear_o",     acc_clear_o,     h.kind == K_LOAD && act_valid_i && !stall_i);
      check("wl_en_o",         wl_en_o,         h.kind == K_DRIVE || h.kind == K_CONV);
      check("adc_start_o",     adc_start_o,     h.kind == K_DRIVE && !stall_i);
      check("acc_en_o",        acc_en_o,        h.kind == K_ACC && !stall_i);
      check("acc_msb_o",       acc_msb_o,       is_dca && h.bitp == m_nbits - 1);
      check("bit_idx_o",       bit_idx_o,       h.bitp);
      check("tile_idx_o",      tile_idx_o,      h.tile);
      check("wb_valid_o",      wb_valid_o,      h.kind == K_WB);
      check("done_o",          done_o,          h.kind == K_DONE && !stall_i);
      check("adc_ref_shift_o", adc_ref_shift_o, m_shift);
      if (busy_o) st_busy++;
      if (acc_en_o) begin
        st_acc++;
        acc_bits.push_back(int'(bit_idx_o));
        acc_tiles.push_back(int'(tile_idx_o));
        if (acc_msb_o) st_msb++;
      end
      if (acc_clear_o) st_clr++;
      if (done_o) begin st_done++; st_done_at = st_busy; end
      if (wb_valid_o) st_wbv++;
      if (act_ready_o) st_rdy++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string name);
    check(name, {busy_o, act_ready_o, wl_en_o, adc_start_o, acc_clear_o, acc_en_o, acc_msb_o,
                 wb_valid_o, done_o, bit_idx_o, tile_idx_o, adc_ref_shift_o}, 0);
  endtask

  task automatic launch(input int ncfg, input bit bin, input int shift);
    clear_stats();
    n_input_bits_cfg_i     = 3'(ncfg);
    binary_cfg_i           = bin;
    adc_ref_range_shifts_i = 3'(shift);
    start_i = 1'b0;
    tick();
    start_i = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (!busy_o && n < 4) begin tick(); n++; end
    n = 0;
    while (busy_o && n < budget) begin tick(); n++; end
    check("op_completes", busy_o, 0);
  endtask

  initial begin
    int  n;
    bit  seen;
    #1 rst = 1'b1;
    #2 check_zero("reset_state");
    tick(); tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= busy_o; end
    check("start_held_no_launch", seen, 0);
    act_valid_i = 1'b1;
    wb_ready_i  = 1'b1;

    // Nominal four-plane operation.
    launch(3, 1'b0, 5);
    wait_idle(200);
    check("t1_busy_cycles", st_busy, 36);
    check("t1_done_at_last", st_done_at, 36);
    check("t1_done_count", st_done, 1);
    check("t1_acc_en_count", st_acc, 8);
    check("t1_acc_clear_count", st_clr, 2);
    check("t1_msb_count", st_msb, 2);
    for (int i = 0; i < acc_bits.size() && i < 8; i++) check("t1_acc_bit_seq", acc_bits[i], i % 4);
    check("t1_ref_shift", adc_ref_shift_o, 5);

    // Binary mode: one plane per tile.
    launch(3, 1'b1, 2);
    wait_idle(200);
    check("t2_busy_cycles", st_busy, 12);
    check("t2_acc_en_count", st_acc, 2);
    check("t2_msb_count", st_msb, 2);
    for (int i = 0; i < acc_tiles.size() && i < 2; i++) check("t2_acc_tile_seq", acc_tiles[i], i);

    // Activation and writeback back-pressure.
    act_valid_i = 1'b0;
    wb_ready_i  = 1'b0;
    launch(3, 1'b0, 1);
    for (int i = 0; i < 5; i++) tick();
    check("t3_ready_while_waiting", act_ready_o, 1);
    check("t3_no_drive_while_waiting", wl_en_o, 0);
    act_valid_i = 1'b1;
    n = 0;
    while (!wb_valid_o && n < 100) begin tick(); n++; end
    check("t3_reach_writeback", wb_valid_o, 1);
    tick(); tick(); tick();
    wb_ready_i = 1'b1;
    wait_idle(50);
    check("t3_busy_cycles", st_busy, 43);
    check("t3_wb_valid_cycles", st_wbv, 4);
    check("t3_act_ready_cycles", st_rdy, 6);
    check("t3_acc_en_count", st_acc, 8);

    // Stall over the first accumulate.
    launch(3, 1'b0, 1);
    n = 0;
    while (!adc_start_o && n < 20) begin tick(); n++; end
    check("t4_reach_drive", adc_start_o, 1);
    tick(); tick(); tick();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t4_stall_acc_en", acc_en_o, 0);
      check("t4_stall_bit", bit_idx_o, 0);
      check("t4_stall_tile", tile_idx_o, 0);
      tick();
    end
    stall_i = 1'b0;
    #1;
    check("t4_post_stall_acc_en", acc_en_o, 1);
    check("t4_post_stall_bit", bit_idx_o, 0);
    tick();
    check("t4_single_acc_en", acc_en_o, 0);
    check("t4_next_bit", bit_idx_o, 1);
    wait_idle(200);
    check("t4_busy_cycles", st_busy, 39);
    check("t4_acc_en_count", st_acc, 8);

    // Abort in tile 1 conversion with start still high.
    launch(3, 1'b0, 0);
    n = 0;
    while (!(tile_idx_o == 1 && wl_en_o && !adc_start_o) && n < 60) begin tick(); n++; end
    check("t5_reach_tile1_convert", wl_en_o, 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    #1;
    check("t5_clear_busy", busy_o, 0);
    check("t5_clear_tile", tile_idx_o, 0);
    check("t5_clear_bit", bit_idx_o, 0);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); seen |= busy_o; end
    check("t5_no_relaunch", seen, 0);
    check("t5_no_done", st_done, 0);
    launch(3, 1'b0, 0);
    wait_idle(200);
    check("t5_relaunch_busy", st_busy, 36);

    // Start edge while busy is ignored; the original config is kept.
    launch(1, 1'b0, 3);
    tick(); tick(); tick();
    start_i = 1'b0;
    tick();
    n_input_bits_cfg_i     = 3'd7;
    adc_ref_range_shifts_i = 3'd6;
    start_i = 1'b1;
    wait_idle(200);
    check("t6_busy_cycles", st_busy, 20);
    check("t6_acc_en_count", st_acc, 4);
    check("t6_done_count", st_done, 1);
    check("t6_ref_shift", adc_ref_shift_o, 3);

    // Asynchronous reset mid-operation.
    launch(7, 1'b0, 6);
    for (int i = 0; i < 5; i++) tick();
    #2 rst = 1'b1;
    #1 check_zero("t6_async_reset");
    tick(); tick();
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin tick(); seen |= busy_o; end
    check("t6_no_launch_after_reset", seen, 0);

    // Randomized traffic against the model.
    for (int c = 0; c < 2500; c++) begin
      stall_i     = ($urandom_range(0, 9) == 0);
      clear_i     = ($urandom_range(0, 299) == 0);
      act_valid_i = ($urandom_range(0, 3) != 0);
      wb_ready_i  = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 5) == 0) start_i = ~start_i;
      n_input_bits_cfg_i     = 3'($urandom_range(0, 7));
      binary_cfg_i           = ($urandom_range(0, 3) == 0);
      adc_ref_range_shifts_i = 3'($urandom_range(0, 7));
      tick();
    end
    stall_i = 1'b0; clear_i = 1'b0; act_valid_i = 1'b1; wb_ready_i = 1'b1; start_i = 1'b0;
    n = 0;
    while (busy_o && n < 300) begin tick(); n++; end
    check("final_idle", busy_o, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qracc_op_sequencer.md
Name: qracc_op_sequencer

Overview:
- Downstream of the QRAcc CSR controller.
- Consumes the CSR START/CLEAR bits and the decoded config fields (n_input_bits_cfg, binary_cfg, adc_ref_range_shifts).
- Sequences one accelerator operation: per row tile, it loads activations, then runs a bit-serial loop of wordline drive, ADC conversion and accumulate over the input bit planes, and finally performs a writeback handshake.
- Reports busy/done back to the CSR status path.

Parameters:
- NUM_TILES, 4, row tiles per operation (>=1).
- ADC_LATENCY, 2, cycles from adc_start_o to valid ADC output (>=1).
- TILE_W, $clog2(NUM_TILES) (min 1), width of tile index.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset, asynchronous, active-high.
- start_i  in  1  CSR START level; an operation launches on its rising edge.
- clear_i  in  1  CSR CLEAR; synchronous abort.
- stall_i  in  1  global freeze.
- n_input_bits_cfg_i  in  3  bit planes minus one.
- binary_cfg_i  in  1  force a single bit plane.
- adc_ref_range_shifts_i  in  3  passed through, latched.
- act_valid_i  in  1  activation tile available.
- act_ready_o  out  1  sequencer accepts the tile.
- wl_en_o  out  1  wordline drive.
- adc_start_o  out  1  ADC conversion start pulse.
- adc_ref_shift_o  out  3  latched ADC reference shift.
- acc_clear_o  out  1  clear accumulator (pulse at tile start).
- acc_en_o  out  1  accumulate pulse.
- bit_idx_o  out  3  current bit plane; also the accumulator shift amount.
- acc_msb_o  out  1  current plane is the last (MSB) plane.
- tile_idx_o  out  TILE_W  current tile.
- wb_valid_o  out  1  results ready.
- wb_ready_i  in  1  writeback sink ready.
- busy_o  out  1  state != IDLE.
- done_o  out  1  one-cycle completion pulse.

Behaviour:
- Reset is asynchronous and active-high. On reset:
  - state=IDLE; all outputs 0.
  - start_q (the registered start_i) resets to 0.
- Start edge: start_edge = start_i & ~start_q.
  - Accepted only in IDLE; the state becomes LOAD the next cycle.
  - On acceptance, latch nbits = binary_cfg_i ? 1 : n_input_bits_cfg_i+1 (range 1..8), and latch adc_ref_range_shifts_i into adc_ref_shift_o.
  - Edges while busy are ignored, not queued.
- States: IDLE, LOAD, DRIVE, CONVERT, ACCUM, WRITEBACK, DONE.
  - LOAD: act_ready_o=1. On act_valid_i: acc_clear_o pulses, bit_idx=0, go to DRIVE.
  - DRIVE: wl_en_o=1 and adc_start_o=1 for one cycle; load a countdown of ADC_LATENCY; go to CONVERT.
  - CONVERT: wl_en_o=1. Decrement each cycle; when the count reaches 0, go to ACCUM. CONVERT lasts exactly ADC_LATENCY cycles.
  - ACCUM: acc_en_o=1 for one cycle. Then:
    - if bit_idx==nbits-1 and tile==NUM_TILES-1: go to WRITEBACK;
    - else if bit_idx==nbits-1: tile++, go to LOAD;
    - else: bit_idx++, go to DRIVE.
  - WRITEBACK: wb_valid_o=1 until wb_ready_i; then go to DONE. wb_valid_o must not drop before the handshake.
  - DONE: done_o=1 for one cycle; go to IDLE. Tile and bit counters return to 0.
- Output values by state:
  - acc_msb_o = (bit_idx==nbits-1) in DRIVE/CONVERT/ACCUM.
  - bit_idx_o and tile_idx_o hold their values in all non-IDLE states and are 0 in IDLE.
- Stall:
  - While stall_i=1, state, counters and latched config hold.
  - Pulse outputs (adc_start_o, acc_en_o, acc_clear_o, done_o) and act_ready_o are forced 0.
  - wl_en_o and wb_valid_o hold.
  - A pulse blocked by a stall is issued on the first unstalled cycle, exactly once.
  - start_q still updates during a stall, so a start edge arriving during a stall is lost.
- clear_i:
  - Forces IDLE next cycle from any state and zeroes the counters.
  - Has priority over stall_i and start_edge in the same cycle. A start edge coincident with clear is dropped.
  - No done_o is produced on abort.
- Boundary cases:
  - nbits=1 or binary mode: each tile is one DRIVE/CONVERT/ACCUM pass.
  - NUM_TILES=1: LOAD happens once.
  - If start_i is held high out of reset, it produces no launch until it falls and rises again.
- Timing: with no stalls, act_valid_i=1 and wb_ready_i=1, busy duration = NUM_TILES*(1+nbits*(2+ADC_LATENCY)) + 2 cycles.

Decomposition:
- Add seq_state_t (enum of the 7 states) to qracc_pkg.
- Add a qracc_seq_ctrl_t struct to qracc_pkg bundling wl_en, adc_start, acc_clear, acc_en, bit_idx and acc_msb, so it can be folded into qracc_control_t.
- Reuse qracc_config_t for the config inputs where convenient.
- No sub-module is needed; the ADC countdown is inline.

Test Plan:
- Run with NUM_TILES=2, ADC_LATENCY=2, n_input_bits_cfg=3, binary=0, no stalls, start rising at cycle 0 -> busy_o for 36 cycles, done_o in the final busy cycle, 8 acc_en pulses with bit_idx 0,1,2,3,0,1,2,3, and 2 acc_clear pulses.
- Same run with binary_cfg=1 -> nbits=1; busy 12 cycles; acc_en pulses with tile_idx 0 then 1; acc_msb_o=1 on both.
- Hold act_valid_i low for 5 cycles in LOAD, then hold wb_ready_i low for 3 cycles -> act_ready_o stays high and no DRIVE occurs until valid; wb_valid_o stays high 4 cycles; total busy extends by 7 cycles.
- Assert stall_i for 3 cycles in the cycle an ACCUM would fire -> acc_en_o=0 during the stall, exactly one acc_en_o after it, and all counters unchanged across the stall.
- Assert clear_i mid-CONVERT of tile 1, with start_i still high -> IDLE next cycle, busy_o=0, no done_o, counters 0; no relaunch until start_i falls and rises again.
- Assert rst mid-operation; also pulse start_i while busy -> all outputs 0 asynchronously on reset; the busy-time start edge is ignored and the operation completes with the original config.
